// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall, bubble insertion and EX flush.
// Optional perf counters are built only when ID_EX_PERF_EN is defined.
module id_ex_stage_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              JalrD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [3:0]        ALUControlD,
    input  logic [2:0]        Funct3D,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic              ValidD,
    input  logic              FlushE,
    input  logic              HoldE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              JalrE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [3:0]        ALUControlE,
    output logic [2:0]        Funct3E,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic              ValidE,
    output logic              StallF,
    output logic              StallD,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [1:0]        result_src;
        logic              mem_write;
        logic              jump;
        logic              jalr;
        logic              branch;
        logic              alu_src;
        logic [3:0]        alu_control;
        logic [2:0]        funct3;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   imm_ext;
    } ex_t;

    ex_t  ex_q, ex_d, cap;
    logic lu;
    logic take_lu;

    // Load in EX whose destination is read by the valid instruction in ID.
    assign lu = ex_q.valid & ex_q.reg_write & (ex_q.result_src == 2'b01)
              & (ex_q.rd != '0) & ((ex_q.rd == Rs1D) | (ex_q.rd == Rs2D)) & ValidD;

    assign StallF  = (lu | HoldE) & ~FlushE;
    assign StallD  = StallF;
    assign take_lu = lu & ~FlushE & ~HoldE;

    always_comb begin
        cap             = '0;
        cap.valid       = ValidD;
        cap.reg_write   = RegWriteD & ValidD;
        cap.result_src  = ValidD ? ResultSrcD : 2'b00;
        cap.mem_write   = MemWriteD & ValidD;
        cap.jump        = JumpD & ValidD;
        cap.jalr        = JalrD & ValidD;
        cap.branch      = BranchD & ValidD;
        cap.alu_src     = ALUSrcD;
        cap.alu_control = ALUControlD;
        cap.funct3      = Funct3D;
        cap.rs1         = Rs1D;
        cap.rs2         = Rs2D;
        cap.rd          = RdD;
        cap.rd1         = RD1D;
        cap.rd2         = RD2D;
        cap.pc          = PCD;
        cap.pc_plus4    = PCPlus4D;
        cap.imm_ext     = ImmExtD;
    end

    always_comb begin
        ex_d = ex_q;
        if (FlushE) begin
            ex_d = '0;
        end else if (HoldE) begin
            ex_d = ex_q;
        end else if (lu) begin
            ex_d = '0;
        end else begin
            ex_d = cap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ValidE      = ex_q.valid;
    assign RegWriteE   = ex_q.reg_write;
    assign ResultSrcE  = ex_q.result_src;
    assign MemWriteE   = ex_q.mem_write;
    assign JumpE       = ex_q.jump;
    assign JalrE       = ex_q.jalr;
    assign BranchE     = ex_q.branch;
    assign ALUSrcE     = ex_q.alu_src;
    assign ALUControlE = ex_q.alu_control;
    assign Funct3E     = ex_q.funct3;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign ImmExtE     = ex_q.imm_ext;

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (take_lu && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (FlushE && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = take_lu;
    assign StallCnt    = '0;
    assign FlushCnt    = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg (counters checked per ID_EX_PERF_EN).
module tb_id_ex_stage_reg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              RegWriteD, MemWriteD, JumpD, JalrD, BranchD, ALUSrcD, ValidD;
    logic [1:0]        ResultSrcD;
    logic [3:0]        ALUControlD;
    logic [2:0]        Funct3D;
    logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
    logic [XLEN-1:0]   RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic              FlushE, HoldE;
    logic              RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, ValidE;
    logic [1:0]        ResultSrcE;
    logic [3:0]        ALUControlE;
    logic [2:0]        Funct3E;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic [XLEN-1:0]   RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic              StallF, StallD;
    logic [CNT_W-1:0]  StallCnt, FlushCnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    id_ex_stage_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .JalrD(JalrD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .Funct3D(Funct3D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .ValidD(ValidD), .FlushE(FlushE), .HoldE(HoldE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .Funct3E(Funct3E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .ValidE(ValidE), .StallF(StallF), .StallD(StallD),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an instruction into ID; unlisted fields go to zero.
    task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                         input logic br, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [31:0] d1);
        ValidD = v; RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw; BranchD = br;
        JumpD = 1'b0; JalrD = 1'b0; ALUSrcD = 1'b0; ALUControlD = 4'h0; Funct3D = 3'h0;
        Rs1D = r1; Rs2D = r2; RdD = rd; RD1D = d1; RD2D = 32'h0;
        PCD = 32'h0; PCPlus4D = 32'h0; ImmExtD = 32'h0;
    endtask

    task automatic load_use_pair();
        drive(1, 1, 2'b01, 0, 0, 5'd0, 5'd0, 5'd5, 32'h0);
        tick();
        drive(1, 1, 2'b00, 0, 0, 5'd5, 5'd1, 5'd6, 32'h0);
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; FlushE = 1'b0; HoldE = 1'b0;
        drive(0, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
        #7;
        chk("reset_ValidE", ValidE, 0);
        chk("reset_RegWriteE", RegWriteE, 0);
        chk("reset_StallCnt", StallCnt, 0);
        rst_n = 1'b1;

        // add x3,x1,x2
        drive(1, 1, 2'b00, 0, 0, 5'd1, 5'd2, 5'd3, 32'h11);
        PCD = 32'h100; PCPlus4D = 32'h104;
        tick();
        chk("add_RegWriteE", RegWriteE, 1);
        chk("add_RdE", RdE, 3);
        chk("add_ValidE", ValidE, 1);
        chk("add_RD1E", RD1E, 32'h11);
        chk("add_PCPlus4E", PCPlus4E, 32'h104);

        // mid-cycle async reset
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ValidE", ValidE, 0);
        chk("midrst_RdE", RdE, 0);
        chk("midrst_RD1E", RD1E, 0);
        rst_n = 1'b1;

        // lw x5 ; add x6,x5,x1
        drive(1, 1, 2'b01, 0, 0, 5'd2, 5'd0, 5'd5, 32'h0);
        tick();
        chk("lw_ResultSrcE", ResultSrcE, 2'b01);
        drive(1, 1, 2'b00, 0, 0, 5'd5, 5'd1, 5'd6, 32'h0);
        #1;
        chk("lu_StallF", StallF, 1);
        chk("lu_StallD", StallD, 1);
        tick();
        chk("lu_bubble_ValidE", ValidE, 0);
        chk("lu_bubble_RegWriteE", RegWriteE, 0);
        chk("lu_bubble_RdE", RdE, 0);
        chk("lu_after_StallF", StallF, 0);
        tick();
        chk("lu_dep_RdE", RdE, 6);
        chk("lu_dep_ValidE", ValidE, 1);

        // lw x0 ; add x7,x0,x0 -> no stall
        drive(1, 1, 2'b01, 0, 0, 5'd2, 5'd0, 5'd0, 32'h0);
        tick();
        drive(1, 1, 2'b00, 0, 0, 5'd0, 5'd0, 5'd7, 32'h0);
        #1;
        chk("x0_StallF", StallF, 0);
        tick();
        chk("x0_RdE", RdE, 7);

        // flush with beq in D
        drive(1, 0, 2'b00, 0, 1, 5'd1, 5'd2, 5'd0, 32'h0);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        chk("flush_ValidE", ValidE, 0);
        chk("flush_BranchE", BranchE, 0);

        // flush coinciding with load-use
        drive(1, 1, 2'b01, 0, 0, 5'd2, 5'd0, 5'd5, 32'h0);
        tick();
        drive(1, 1, 2'b00, 0, 0, 5'd5, 5'd1, 5'd6, 32'h0);
        FlushE = 1'b1;
        #1;
        chk("flushlu_StallF", StallF, 0);
        tick();
        FlushE = 1'b0;
        chk("flushlu_ValidE", ValidE, 0);
        chk("flushlu_RdE", RdE, 0);

        // hold for 3 cycles, flush on the 2nd
        drive(1, 1, 2'b00, 0, 0, 5'd1, 5'd2, 5'd8, 32'hAA);
        tick();
        chk("hold_pre_RdE", RdE, 8);
        drive(1, 1, 2'b00, 0, 0, 5'd1, 5'd2, 5'd9, 32'hBB);
        HoldE = 1'b1;
        #1;
        chk("hold_StallD", StallD, 1);
        tick();
        chk("hold1_RdE", RdE, 8);
        chk("hold1_RD1E", RD1E, 32'hAA);
        chk("hold1_ValidE", ValidE, 1);
        FlushE = 1'b1;
        #1;
        chk("holdflush_StallD", StallD, 0);
        tick();
        FlushE = 1'b0;
        chk("hold2_ValidE", ValidE, 0);
        chk("hold2_RdE", RdE, 0);
        tick();
        chk("hold3_RD1E", RD1E, 0);
        HoldE = 1'b0;
        tick();
        chk("hold_release_RdE", RdE, 9);
        chk("hold_release_RD1E", RD1E, 32'hBB);

        // full-field capture: jalr with funct3/imm/ALU fields
        drive(1, 1, 2'b10, 0, 0, 5'd3, 5'd4, 5'd1, 32'h55);
        JumpD = 1'b1; JalrD = 1'b1; ALUSrcD = 1'b1; ALUControlD = 4'hA;
        Funct3D = 3'h5; ImmExtD = 32'hFFFF_FFF0; PCD = 32'h200; RD2D = 32'h66;
        tick();
        chk("jalr_JumpE", JumpE, 1);
        chk("jalr_JalrE", JalrE, 1);
        chk("jalr_ResultSrcE", ResultSrcE, 2'b10);
        chk("jalr_ALUControlE", ALUControlE, 4'hA);
        chk("jalr_Funct3E", Funct3E, 3'h5);
        chk("jalr_ImmExtE", ImmExtE, 32'hFFFF_FFF0);
        chk("jalr_PCE", PCE, 32'h200);
        chk("jalr_RD2E", RD2E, 32'h66);
        chk("jalr_Rs2E", Rs2E, 4);

        // capture with ValidD=0: controls forced low, data kept
        drive(0, 1, 2'b01, 1, 1, 5'd1, 5'd2, 5'd10, 32'hCC);
        JumpD = 1'b1; JalrD = 1'b1;
        tick();
        chk("inv_RegWriteE", RegWriteE, 0);
        chk("inv_MemWriteE", MemWriteE, 0);
        chk("inv_JumpE", JumpE, 0);
        chk("inv_BranchE", BranchE, 0);
        chk("inv_ResultSrcE", ResultSrcE, 0);
        chk("inv_RdE", RdE, 10);
        chk("inv_RD1E", RD1E, 32'hCC);

        // load-use via Rs2
        drive(1, 1, 2'b01, 0, 0, 5'd0, 5'd0, 5'd4, 32'h0);
        tick();
        drive(1, 0, 2'b00, 1, 0, 5'd1, 5'd4, 5'd0, 32'h0);
        #1;
        chk("lu_rs2_StallF", StallF, 1);
        tick();
        tick();
        chk("lu_rs2_MemWriteE", MemWriteE, 1);

        // load followed by invalid ID slot: no stall
        drive(1, 1, 2'b01, 0, 0, 5'd0, 5'd0, 5'd4, 32'h0);
        tick();
        drive(0, 0, 2'b00, 0, 0, 5'd4, 5'd0, 5'd0, 32'h0);
        #1;
        chk("lu_invalid_StallF", StallF, 0);
        tick();

        // two more load-use stalls: 4 stalls, 3 flush edges so far
        load_use_pair();
        load_use_pair();
`ifdef ID_EX_PERF_EN
        chk("perf_StallCnt", StallCnt, 4);
        chk("perf_FlushCnt", FlushCnt, 3);
        for (int i = 0; i < 4; i++) load_use_pair();
        chk("perf_StallCnt_sat", StallCnt, 7);
`else
        chk("noperf_StallCnt", StallCnt, 0);
        chk("noperf_FlushCnt", FlushCnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
